// File: rtl/bist_cut_controller.sv
// Self-test driver: 60-bit LFSR stimulus, 26-bit MISR compaction, start/done handshake.
// Optional golden-signature comparator is built when BIST_GOLDEN_CMP_EN is defined.
module bist_cut_controller #(
    parameter int unsigned NUM_PATTERNS = 1000,
    parameter logic [59:0] SEED         = 60'h1,
    parameter int unsigned RESP_LAT     = 0,
    parameter logic [25:0] GOLDEN_SIG   = 26'h0
) (
    input  logic        CK,
    input  logic        RSTN,
    input  logic        start,
    input  logic        abort,
    output logic [59:0] pi_vec,
    input  logic [25:0] po_vec,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [25:0] signature,
    output logic [15:0] pat_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [15:0] LAST_PAT = 16'(NUM_PATTERNS - 1);

    state_t      state;
    state_t      state_nxt;
    logic        apply;
    logic        vld;
    logic        drain_end;
    logic        kill;
    logic        fb;
    logic [59:0] pi_nxt;
    logic [25:0] sig_nxt;
    logic [15:0] cnt_nxt;

    // abort is ignored in IDLE; everywhere else it freezes the datapath
    assign kill = abort && (state != ST_IDLE);

    always_ff @(posedge CK) begin
        if (!RSTN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SEED;
            ST_SEED:  state_nxt = ST_RUN;
            ST_RUN:   if (pat_count == LAST_PAT)
                          state_nxt = (RESP_LAT > 0) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_SEED;
            default:  state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy  = (state == ST_SEED) || (state == ST_RUN) || (state == ST_DRAIN);
        done  = (state == ST_DONE);
        apply = (state == ST_RUN) && !abort;
    end

    // Response-valid pipe: the apply strobe delayed by RESP_LAT cycles
    generate
        if (RESP_LAT == 0) begin : g_nolat
            assign vld       = apply;
            assign drain_end = 1'b1;
        end else begin : g_lat
            logic [RESP_LAT-1:0] vpipe;
            always_ff @(posedge CK) begin
                if (!RSTN || kill || state == ST_SEED) vpipe <= '0;
                else                                   vpipe <= RESP_LAT'({vpipe, apply});
            end
            assign vld = vpipe[RESP_LAT-1];
            // the strobe leaving this cycle is the last one in flight
            assign drain_end = (RESP_LAT'(vpipe << 1) == '0);
        end
    endgenerate

    assign fb = signature[25] ^ signature[5] ^ signature[1] ^ signature[0];

    always_comb begin
        pi_nxt  = pi_vec;
        sig_nxt = signature;
        cnt_nxt = pat_count;
        if (!kill) begin
            if (state == ST_SEED) begin
                pi_nxt  = SEED;
                sig_nxt = '0;
                cnt_nxt = '0;
            end
            if (state == ST_RUN) begin
                cnt_nxt = pat_count + 16'd1;
                pi_nxt  = {pi_vec[58:0], pi_vec[59] ^ pi_vec[58]};
            end
            if (vld) sig_nxt = {signature[24:0], fb} ^ po_vec;
        end
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            pi_vec    <= '0;
            signature <= '0;
            pat_count <= '0;
        end else begin
            pi_vec    <= pi_nxt;
            signature <= sig_nxt;
            pat_count <= cnt_nxt;
        end
    end

`ifdef BIST_GOLDEN_CMP_EN
    // Verdict is latched on the DONE entry edge using the final signature
    always_ff @(posedge CK) begin
        if (!RSTN)                                          pass <= 1'b0;
        else if (state_nxt == ST_DONE && state != ST_DONE)  pass <= (sig_nxt == GOLDEN_SIG);
        else if (state_nxt != ST_DONE)                      pass <= 1'b0;
    end
`else
    assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_bist_cut_controller.sv
// Randomized self-checking bench for bist_cut_controller against a run-level behavioural model.
module tb_bist_cut_controller;

    localparam int          N   = 24;
    localparam int          LAT = 2;
    localparam logic [59:0] SD  = 60'h1;
`ifdef BIST_GOLDEN_CMP_EN
    localparam bit GCMP = 1'b1;
`else
    localparam bit GCMP = 1'b0;
`endif

    function automatic logic [59:0] lstep(input logic [59:0] v);
        return {v[58:0], v[59] ^ v[58]};
    endfunction

    function automatic logic [25:0] mstep(input logic [25:0] s, input logic [25:0] r);
        logic f;
        f = s[25] ^ s[5] ^ s[1] ^ s[0];
        return {s[24:0], f} ^ r;
    endfunction

    function automatic logic [25:0] cut_f(input logic [59:0] p, input int unsigned md,
                                          input logic [25:0] mk);
        if (md == 0) return 26'h0;
        if (md == 1) return 26'h1;
        return p[25:0] ^ p[59:34] ^ mk;
    endfunction

    function automatic logic [25:0] gold_sig();
        logic [25:0] s;
        logic [59:0] p;
        s = '0;
        p = SD;
        for (int k = 0; k < N; k++) begin
            s = mstep(s, cut_f(p, 2, 26'h0));
            p = lstep(p);
        end
        return s;
    endfunction

    localparam logic [25:0] GOLD = gold_sig();

    logic        CK, RSTN, start, abort;
    logic [59:0] pi_vec;
    logic [25:0] po_vec;
    logic        busy, done, pass;
    logic [25:0] signature;
    logic [15:0] pat_count;

    bist_cut_controller #(
        .NUM_PATTERNS(N),
        .SEED(SD),
        .RESP_LAT(LAT),
        .GOLDEN_SIG(GOLD)
    ) dut (
        .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
        .pi_vec(pi_vec), .po_vec(po_vec), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .pat_count(pat_count)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Emulated CUT: combinational function of pi_vec, registered twice (LAT=2)
    int unsigned mode;
    logic [25:0] mask;
    logic        flip_en;
    int          flip_k;
    logic [59:0] flip_pat;
    int unsigned flip_bit;
    logic [25:0] d1, d2;

    always @(posedge CK) begin
        logic [25:0] r;
        r = cut_f(pi_vec, mode, mask);
        if (flip_en && pi_vec == flip_pat) r = r ^ (26'(1) << flip_bit);
        d1 <= r;
        d2 <= d1;
    end
    assign po_vec = d2;

    // Run-level model: pattern list and signature after k compactions
    logic [59:0] mpat [0:N];
    logic [25:0] msig [0:N];
    bit          run;
    bit          chk_en;
    int          c;
    logic [59:0] h_pi;
    logic [25:0] h_sig;
    logic [15:0] h_cnt;

    task automatic build();
        logic [25:0] r;
        mpat[0] = SD;
        msig[0] = '0;
        for (int k = 0; k < N; k++) begin
            r = cut_f(mpat[k], mode, mask);
            if (flip_en && k == flip_k) r = r ^ (26'(1) << flip_bit);
            msig[k+1] = mstep(msig[k], r);
            mpat[k+1] = lstep(mpat[k]);
        end
    endtask

    task automatic exp_now(output logic [59:0] e_pi, output logic [25:0] e_sig,
                           output logic [15:0] e_cnt, output logic e_busy,
                           output logic e_done, output logic e_pass);
        int k, j;
        e_pi = h_pi; e_sig = h_sig; e_cnt = h_cnt;
        e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
        if (run && c == 1) begin
            e_busy = 1'b1;
        end else if (run) begin
            k = (c - 2 < N) ? c - 2 : N;
            j = c - 2 - LAT;
            if (j < 0) j = 0;
            if (j > N) j = N;
            e_cnt  = 16'(k);
            e_pi   = mpat[k];
            e_sig  = msig[j];
            e_busy = (c < N + 2 + LAT);
            e_done = !e_busy;
            e_pass = e_done && GCMP && (msig[N] == GOLD);
        end
    endtask

    initial begin
        run = 0; chk_en = 0; c = 0;
        h_pi = '0; h_sig = '0; h_cnt = '0;
    end

    always @(posedge CK) begin
        logic [59:0] e_pi; logic [25:0] e_sig; logic [15:0] e_cnt;
        logic e_busy, e_done, e_pass;
        if (!RSTN) begin
            run = 0; chk_en = 1;
            h_pi = '0; h_sig = '0; h_cnt = '0;
        end else if (!run) begin
            if (start) begin build(); run = 1; c = 1; end
        end else begin
            exp_now(e_pi, e_sig, e_cnt, e_busy, e_done, e_pass);
            if (abort) begin
                h_pi = e_pi; h_sig = e_sig; h_cnt = e_cnt; run = 0;
            end else if (e_done && start) begin
                h_pi = e_pi; h_sig = e_sig; h_cnt = e_cnt;
                build(); c = 1;
            end else begin
                c++;
            end
        end
    end

    always @(negedge CK) begin
        logic [59:0] e_pi; logic [25:0] e_sig; logic [15:0] e_cnt;
        logic e_busy, e_done, e_pass;
        if (chk_en) begin
            exp_now(e_pi, e_sig, e_cnt, e_busy, e_done, e_pass);
            check("pi_vec",    pi_vec,    e_pi);
            check("signature", signature, e_sig);
            check("pat_count", pat_count, e_cnt);
            check("busy",      busy,      e_busy);
            check("done",      done,      e_done);
            check("pass",      pass,      e_pass);
        end
    end

    function automatic logic [59:0] lfsr_adv(input int k);
        logic [59:0] p;
        p = SD;
        for (int i = 0; i < k; i++) p = lstep(p);
        return p;
    endfunction

    // Drive an optional start, then step until done, abort point or cycle budget
    task automatic do_run(input bit do_start, input int cc0, input int abort_at,
                          input bit rnd_start, output bit got_done);
        bit fin;
        int cc;
        fin = 0;
        got_done = 0;
        cc = cc0;
        if (do_start) begin
            start = 1'b1;
            @(negedge CK);
            start = 1'b0;
        end
        while (!fin && cc <= N + LAT + 20) begin
            if (done) begin
                fin = 1;
                got_done = 1;
                check("done_cycle", 64'(cc), 64'(N + 2 + LAT));
            end else if (abort_at == cc) begin
                abort = 1'b1;
                @(negedge CK);
                abort = 1'b0;
                fin = 1;
            end else begin
                start = rnd_start && ($urandom_range(0, 2) == 0);
                @(negedge CK);
                start = 1'b0;
                cc++;
            end
        end
        if (!fin) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit ok;
        int guard;
        RSTN = 1'b0; start = 1'b0; abort = 1'b0;
        mode = 0; mask = '0; flip_en = 1'b0; flip_k = 0; flip_pat = '0; flip_bit = 0;
        repeat (3) @(negedge CK);
        check("rst_pi", pi_vec, 64'd0);
        check("rst_busy", busy, 64'd0);
        RSTN = 1'b1;

        // abort while idle does nothing
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        check("idle_abort_busy", busy, 64'd0);

        // constant-1 responses: LFSR sequence and first compaction pinned by hand
        mode = 1;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        check("busy_after_start", busy, 64'd1);
        @(negedge CK); check("lfsr_p0", pi_vec, 64'h1);
        @(negedge CK); check("lfsr_p1", pi_vec, 64'h2);
        @(negedge CK); check("lfsr_p2", pi_vec, 64'h4);
        @(negedge CK);
        check("misr_first", signature, 64'h1);
        check("cnt_at_c5", pat_count, 64'd3);
        do_run(1'b0, 5, 0, 1'b1, ok);
        check("final_cnt", pat_count, 64'(N));

        // zero responses leave the signature at zero
        mode = 0;
        do_run(1'b1, 1, 0, 1'b1, ok);
        check("zero_sig", signature, 64'h0);

        // abort and start together in DONE: abort wins
        abort = 1'b1; start = 1'b1;
        @(negedge CK);
        abort = 1'b0; start = 1'b0;
        check("done_abort_busy", busy, 64'd0);
        check("done_abort_done", done, 64'd0);

        // randomized runs with optional fault flip and abort point
        for (int r = 0; r < 10; r++) begin
            mode = 2;
            mask = 26'($urandom);
            flip_en = 1'($urandom_range(0, 1));
            flip_k = int'($urandom_range(0, N - 1));
            flip_pat = lfsr_adv(flip_k);
            flip_bit = $urandom_range(0, 25);
            do_run(1'b1, 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + LAT + 1)) : 0,
                   1'b1, ok);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                abort = ok ? 1'b0 : 1'($urandom_range(0, 1));
                @(negedge CK);
                abort = 1'b0;
            end
        end

        // abort at pat_count 10, then restart from SEED
        flip_en = 1'b0;
        mask = 26'($urandom);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        guard = 0;
        while (!(busy && pat_count == 16'd10) && guard < 40) begin
            @(negedge CK);
            guard++;
        end
        check("reach_cnt10", 64'(guard < 40), 64'd1);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        check("abort_busy", busy, 64'd0);
        check("abort_done", done, 64'd0);
        check("abort_cnt_held", pat_count, 64'd10);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        @(negedge CK);
        check("restart_cnt", pat_count, 64'd0);
        do_run(1'b0, 2, 0, 1'b1, ok);

        // synchronous reset in the middle of a run
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        repeat (N / 2) @(negedge CK);
        RSTN = 1'b0;
        @(negedge CK);
        RSTN = 1'b1;
        check("mid_rst_pi", pi_vec, 64'd0);
        check("mid_rst_sig", signature, 64'd0);
        check("mid_rst_cnt", pat_count, 64'd0);
        check("mid_rst_busy", busy, 64'd0);
        check("mid_rst_done", done, 64'd0);
        @(negedge CK);
        do_run(1'b1, 1, 0, 1'b0, ok);
        check("post_rst_done", 64'(ok), 64'd1);

        // golden-signature run, then the same run with one flipped response bit
        mode = 2; mask = '0; flip_en = 1'b0;
        do_run(1'b1, 1, 0, 1'b0, ok);
        check("golden_pass", pass, 64'(GCMP));
        flip_en = 1'b1; flip_k = 7; flip_pat = lfsr_adv(7); flip_bit = 13;
        do_run(1'b1, 1, 0, 1'b0, ok);
        check("flipped_pass", pass, 64'd0);
        flip_en = 1'b0;
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        check("pass_while_busy", pass, 64'd0);
        do_run(1'b0, 1, 0, 1'b1, ok);
        repeat (3) @(negedge CK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
